// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
//   CNT_W      : width of the debounce and hold counters
//   COUNT_W    : width of the press counter
//   state_t    : press-tracking FSM encoding (IDLE=0, HELD=1, LONG=2)
//   ms_to_cycles : converts a millisecond interval to clock cycles, minimum 1
package button_debouncer_pkg;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    // Cycle count for an interval; a zero result is clamped to one cycle.
    function automatic longint unsigned ms_to_cycles(input longint unsigned freq,
                                                     input longint unsigned ms);
        longint unsigned cyc;
        cyc = freq / 64'd1000 * ms;
        return (cyc == 64'd0) ? 64'd1 : cyc;
    endfunction

endpackage

// File: rtl/button_debouncer_sync_debounce.sv
// Two-flop synchroniser followed by a stability filter.
// A level change is accepted once the synchronised input has disagreed with
// the accepted level for DEB_CYC consecutive cycles; any single cycle of
// agreement restarts the count. Reusable for DIP switches and jumpers.
//   CLK          : clock
//   RESETN       : synchronous active-low reset
//   raw          : asynchronous input, 1 = asserted
//   stable       : accepted (debounced) level, registered
//   stable_nxt_c : value stable takes at the next edge (combinational)
module button_debouncer_sync_debounce
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEB_CYC = 1
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic raw,
    output logic stable,
    output logic stable_nxt_c
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] deb_cnt;
    logic             accept_c;

    // Disagreement has lasted DEB_CYC cycles counting this one.
    assign accept_c     = (sync2 != stable) && (deb_cnt == CNT_W'(DEB_CYC - 1));
    assign stable_nxt_c = accept_c ? sync2 : stable;

    // Synchroniser, debounce counter and accepted level.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            stable  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stable <= stable_nxt_c;
            if (sync2 == stable || accept_c) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: debounced level, press/release strobes, a single
// long-press strobe per press, and a wrapping 16-bit press counter.
//   CLK         : system clock
//   RESETN      : synchronous active-low reset
//   BUTTON_IN   : raw pin, asynchronous, may bounce
//   PRESSED     : debounced level, 1 = pressed
//   PRESS       : one-cycle strobe on accepted press
//   RELEASE     : one-cycle strobe on accepted release
//   LONG_PRESS  : one-cycle strobe after LONG_PRESS_MS of continuous press
//   PRESS_COUNT : accepted presses since reset, wraps at 16 bits
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = 100000000,
    parameter int unsigned DEBOUNCE_MS   = 10,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               BUTTON_IN,
    output logic               PRESSED,
    output logic               PRESS,
    output logic               RELEASE,
    output logic               LONG_PRESS,
    output logic [COUNT_W-1:0] PRESS_COUNT
);

    localparam longint unsigned DEB_CYC_L  = ms_to_cycles(64'(CLOCK_FREQ), 64'(DEBOUNCE_MS));
    localparam longint unsigned LONG_CYC_L = ms_to_cycles(64'(CLOCK_FREQ), 64'(LONG_PRESS_MS));

    // Both intervals must fit the 32-bit counters.
    if (DEB_CYC_L >= 64'h1_0000_0000) begin : g_deb_cyc_range
        $error("button_debouncer: debounce interval does not fit 32-bit counter");
    end
    if (LONG_CYC_L >= 64'h1_0000_0000) begin : g_long_cyc_range
        $error("button_debouncer: long-press interval does not fit 32-bit counter");
    end

    localparam int unsigned DEB_CYC  = 32'(DEB_CYC_L);
    localparam int unsigned LONG_CYC = 32'(LONG_CYC_L);

    logic               raw_c;
    logic               stable;
    logic               stable_nxt_c;
    logic               rise_c;
    logic               fall_c;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   hold_q;
    logic [CNT_W-1:0]   hold_d;
    logic [COUNT_W-1:0] count_d;
    logic               pressed_d;
    logic               press_d;
    logic               release_d;
    logic               long_d;

    // Normalise polarity so raw_c is 1 while the button is pressed.
    assign raw_c = BUTTON_IN ^ ACTIVE_LOW;

    button_debouncer_sync_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_sync_debounce (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .raw          (raw_c),
        .stable       (stable),
        .stable_nxt_c (stable_nxt_c)
    );

    // Acting on the accepting edge itself keeps strobes aligned with PRESSED.
    assign rise_c = stable_nxt_c & ~stable;
    assign fall_c = ~stable_nxt_c & stable;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = PRESS_COUNT;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    press_d = 1'b1;
                    count_d = PRESS_COUNT + COUNT_W'(1);
                    hold_d  = '0;
                    state_d = HELD;
                end
            end
            HELD: begin
                hold_d = hold_q + CNT_W'(1);
                // Release takes priority over a coincident long-press expiry.
                if (fall_c) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else if (hold_q == CNT_W'(LONG_CYC - 1)) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            LONG: begin
                if (fall_c) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pressed_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            PRESSED     <= 1'b0;
            PRESS       <= 1'b0;
            RELEASE     <= 1'b0;
            LONG_PRESS  <= 1'b0;
            PRESS_COUNT <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            PRESSED     <= pressed_d;
            PRESS       <= press_d;
            RELEASE     <= release_d;
            LONG_PRESS  <= long_d;
            PRESS_COUNT <= count_d;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with CLOCK_FREQ=1000,
// DEBOUNCE_MS=4, LONG_PRESS_MS=20 (4-cycle debounce, 20-cycle long press).
// A behavioural model derives expected outputs from pin history windows and
// press timestamps; directed scenarios add explicit timing checkpoints.
module tb_button_debouncer;

    localparam int unsigned DEB        = 4;
    localparam int unsigned LONGC      = 20;
    localparam bit          ACTIVE_LOW = 1'b1;

    logic        clk;
    logic        rstn;
    logic        btn;
    logic        pressed;
    logic        press;
    logic        rel;
    logic        long_press;
    logic [15:0] press_count;

    button_debouncer #(
        .CLOCK_FREQ    (1000),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (20),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) dut (
        .CLK         (clk),
        .RESETN      (rstn),
        .BUTTON_IN   (btn),
        .PRESSED     (pressed),
        .PRESS       (press),
        .RELEASE     (rel),
        .LONG_PRESS  (long_press),
        .PRESS_COUNT (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int unsigned t;
    int          long_seen;

    // Reference model state.
    bit          pipe[$];
    bit          win[$];
    bit          m_level;
    bit          long_done;
    int unsigned press_t;
    logic [15:0] m_count;
    bit          e_press;
    bit          e_release;
    bit          e_long;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed %0b expected %0b", tag, t, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Pin reaches the filter two edges late; a level is accepted once the last
    // DEB filtered samples all oppose the current level.
    task automatic model_edge();
        bit raw;
        bit obs;
        bit all_opp;
        e_press   = 1'b0;
        e_release = 1'b0;
        e_long    = 1'b0;
        if (!rstn) begin
            pipe      = {1'b0, 1'b0};
            win       = {};
            m_level   = 1'b0;
            long_done = 1'b0;
            m_count   = 16'h0000;
        end else begin
            raw = btn ^ ACTIVE_LOW;
            obs = pipe.pop_front();
            pipe.push_back(raw);
            win.push_back(obs);
            if (win.size() > DEB) void'(win.pop_front());
            all_opp = (win.size() == DEB);
            foreach (win[i]) if (win[i] == m_level) all_opp = 1'b0;
            if (all_opp && !m_level) begin
                m_level   = 1'b1;
                press_t   = t;
                long_done = 1'b0;
                m_count   = m_count + 16'd1;
                e_press   = 1'b1;
            end else if (all_opp && m_level) begin
                m_level   = 1'b0;
                e_release = 1'b1;
            end else if (m_level && !long_done && (t - press_t == LONGC)) begin
                long_done = 1'b1;
                e_long    = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        model_edge();
        @(negedge clk);
        check("pressed", pressed, m_level);
        check("press", press, e_press);
        check("release", rel, e_release);
        check("long_press", long_press, e_long);
        check16("press_count", press_count, m_count);
        if (long_press === 1'b1) long_seen++;
    endtask

    task automatic tick_to(input int unsigned n);
        while (t < n) tick();
    endtask

    initial begin
        int unsigned len;
        checks    = 0;
        errors    = 0;
        t         = 0;
        long_seen = 0;
        rstn      = 1'b0;
        btn       = 1'b1;

        // Reset state.
        tick_to(3);
        check("rst_pressed", pressed, 1'b0);
        check("rst_press", press, 1'b0);
        check16("rst_count", press_count, 16'h0000);

        // Clean press at edge 10 -> PRESS after edge 15.
        rstn = 1'b1;
        tick_to(9);
        btn = 1'b0;
        tick_to(14);
        check("s1_press_early", press, 1'b0);
        check("s1_pressed_early", pressed, 1'b0);
        tick();
        check("s1_press", press, 1'b1);
        check("s1_pressed", pressed, 1'b1);
        check16("s1_count", press_count, 16'd1);
        tick();
        check("s1_press_once", press, 1'b0);

        // Long press 20 cycles after PRESS, release 6 cycles after pin edge 46.
        tick_to(34);
        check("s3_long_early", long_press, 1'b0);
        tick();
        check("s3_long", long_press, 1'b1);
        tick();
        check("s3_long_once", long_press, 1'b0);
        tick_to(45);
        btn = 1'b1;
        tick_to(50);
        check("s3_rel_early", rel, 1'b0);
        check("s3_still_pressed", pressed, 1'b1);
        tick();
        check("s3_release", rel, 1'b1);
        check("s3_pressed_low", pressed, 1'b0);

        // Bounce every 2 cycles, final edge 89 -> PRESS after edge 94.
        tick_to(60);
        for (int k = 0; k < 15; k++) begin
            btn = ~btn;
            tick();
            tick();
        end
        tick_to(93);
        check("s2_press_early", press, 1'b0);
        tick();
        check("s2_press", press, 1'b1);
        check16("s2_count", press_count, 16'd2);

        // Short press: no long-press strobe.
        btn = 1'b1;
        tick_to(100);
        check("s4_prior_release", rel, 1'b1);
        tick_to(105);
        btn = 1'b0;
        long_seen = 0;
        tick_to(111);
        check("s4_press", press, 1'b1);
        tick_to(121);
        btn = 1'b1;
        tick_to(127);
        check("s4_release", rel, 1'b1);
        check16("s4_count", press_count, 16'd3);
        checks++;
        assert (long_seen == 0)
        else begin
            errors++;
            $error("FAIL s4_no_long observed %0d expected 0", long_seen);
        end

        // Reset mid-press, button still held -> fresh PRESS after edge 149.
        tick_to(132);
        btn = 1'b0;
        tick_to(140);
        check("s5_held", pressed, 1'b1);
        rstn = 1'b0;
        tick();
        check("s5_rst_pressed", pressed, 1'b0);
        check("s5_rst_no_release", rel, 1'b0);
        check16("s5_rst_count", press_count, 16'h0000);
        tick_to(143);
        rstn = 1'b1;
        tick_to(148);
        check("s5_press_early", press, 1'b0);
        tick();
        check("s5_press", press, 1'b1);
        check16("s5_count", press_count, 16'd1);

        // Counter wrap: preload 0xFFFF, next press gives 0, then 1.
        btn = 1'b1;
        tick_to(160);
        force dut.PRESS_COUNT = 16'hFFFF;
        m_count = 16'hFFFF;
        tick();
        release dut.PRESS_COUNT;
        btn = 1'b0;
        tick_to(167);
        check("s6_press", press, 1'b1);
        check16("s6_wrap", press_count, 16'h0000);
        tick_to(170);
        btn = 1'b1;
        tick_to(180);
        btn = 1'b0;
        tick_to(186);
        check("s6_press2", press, 1'b1);
        check16("s6_after_wrap", press_count, 16'h0001);

        // Randomised pin activity with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                rstn = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rstn = 1'b1;
            end
            btn = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 7);
            repeat (len) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side companion to the LED blinker: conditions a raw, asynchronous, bouncing pushbutton or jumper input into clean single-cycle event pulses.
- Provides a debounced level, press/release strobes, a long-press strobe and a press counter.
- Sits at board top level between a package pin and the control logic, e.g. a mode switch or manual reset request.
- Same clocking and reset scheme as the other board-level I/O blocks.

Parameters:
- CLOCK_FREQ, 100000000, CLK frequency in Hz.
- DEBOUNCE_MS, 10, time the input must be continuously stable before a level change is accepted.
- LONG_PRESS_MS, 1000, continuous debounced-press time that raises LONG_PRESS.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- CLK  input  1  system clock.
- RESETN  input  1  synchronous, active-low reset, sampled on CLK.
- BUTTON_IN  input  1  raw pin, asynchronous to CLK, may bounce.
- PRESSED  output  1  debounced level, 1 = pressed.
- PRESS  output  1  one-cycle strobe on an accepted press.
- RELEASE  output  1  one-cycle strobe on an accepted release.
- LONG_PRESS  output  1  one-cycle strobe, at most once per press.
- PRESS_COUNT  output  16  number of accepted presses since reset; wraps 0xFFFF -> 0.

Behaviour:
- Derived constants, integer arithmetic:
  - DEB_CYC = CLOCK_FREQ/1000*DEBOUNCE_MS, forced to 1 if the result is 0.
  - LONG_CYC = CLOCK_FREQ/1000*LONG_PRESS_MS, forced to 1 if the result is 0.
  - Both counters are 32-bit. Elaboration fails if LONG_CYC >= 2^32.
- Polarity: raw = BUTTON_IN XOR ACTIVE_LOW, so raw is 1 when pressed.
- Synchroniser:
  - Two flops, sync1 then sync2.
  - Reset value of both is 0 (released), so a button held through reset is reported as a press after reset.
- Debounce:
  - deb_cnt resets to 0 whenever sync2 == stable.
  - While sync2 != stable, deb_cnt increments each cycle.
  - When sync2 != stable and deb_cnt == DEB_CYC-1, stable <= sync2 and deb_cnt <= 0.
  - A single cycle of agreement with stable restarts the count, so glitches shorter than DEB_CYC cycles are ignored.
- Latency: BUTTON_IN held steady in its new level from clock edge N makes PRESSED change, and the matching strobe assert, in the cycle after edge N+DEB_CYC+1, i.e. DEB_CYC+2 cycles.
- State machine (2 bits):
  - IDLE, on stable 0->1: PRESS=1, PRESS_COUNT+1, hold_cnt <= 0, go to HELD.
  - HELD:
    - hold_cnt increments each cycle.
    - When hold_cnt == LONG_CYC-1: LONG_PRESS=1, go to LONG.
    - On stable 1->0: RELEASE=1, go to IDLE.
  - LONG:
    - hold_cnt is frozen.
    - On stable 1->0: RELEASE=1, go to IDLE.
    - No further LONG_PRESS until the next press.
  - Simultaneous release and hold_cnt == LONG_CYC-1: the release wins; no LONG_PRESS, go to IDLE.
- Outputs are registered.
  - PRESSED = (state != IDLE).
  - PRESS, RELEASE and LONG_PRESS are mutually exclusive and never asserted two cycles in a row.
- Reset (RESETN=0 at a CLK edge):
  - All flops clear: state=IDLE; every output 0; PRESS_COUNT=0.
  - Reset mid-press drops PRESSED immediately with no RELEASE strobe.
  - After RESETN deasserts, a still-pressed button produces a fresh PRESS after DEB_CYC+2 cycles.

Decomposition:
- No shared package is required. The state encoding (IDLE=0, HELD=1, LONG=2) is a localparam.
- Natural sub-module: sync_debounce, holding the synchroniser plus the debounce counter. Parameter DEB_CYC; input raw; output stable. It is reusable for DIP switches.
- The top level holds the polarity XOR, the state machine, hold_cnt and PRESS_COUNT.

Test Plan:
All scenarios use CLOCK_FREQ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=20, so DEB_CYC=4 and LONG_CYC=20.
1. Clean press: ACTIVE_LOW=1; BUTTON_IN 1->0 at edge 10 and held -> PRESS high for exactly the cycle after edge 15; PRESSED=1 from then on; PRESS_COUNT=1.
2. Bounce: toggle BUTTON_IN every 2 cycles for 30 cycles, then hold low -> exactly one PRESS, DEB_CYC+2 cycles after the final edge; no strobes during the bounce.
3. Long press: hold pressed 30 cycles past PRESS -> one LONG_PRESS exactly 20 cycles after PRESS; release -> RELEASE 6 cycles after the pin edge; PRESSED=0.
4. Short press: hold 10 debounced cycles, then release -> PRESS then RELEASE; no LONG_PRESS; PRESS_COUNT increments by 1.
5. Reset mid-press: assert RESETN=0 for 3 cycles while in HELD -> all outputs 0, no RELEASE; pin still pressed -> new PRESS 6 cycles after release of reset; PRESS_COUNT=1.
6. Wrap: force 65536 short presses -> PRESS_COUNT returns to 0; the 65537th press gives 1.
